// File: rtl/count_pulse_gen.sv
// Push-button front end: 2-FF synchroniser, debounce FSM and one-cycle `count` strobe with a wrapping tally.
// Optional auto-repeat while held is enabled by defining COUNT_AUTOREPEAT_EN.
//
// state     | meaning
// IDLE      | button released and stable
// DEB_PRESS | press seen, waiting for it to stay stable
// HELD      | press accepted; auto-repeat timer runs here when enabled
// DEB_REL   | release seen, waiting for it to stay stable
module count_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200,
  parameter int TALLY_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_in,
  output logic               count,
  output logic               pressed,
  output logic [TALLY_W-1:0] tally
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DCNT_TC = DW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : g_param_check
    $error("count_pulse_gen: illegal parameter values");
  end

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t             state, state_nxt;
  logic               s1, btn_s;
  logic [DW-1:0]      dcnt, dcnt_nxt;
  logic               count_nxt, pressed_nxt;
  logic [TALLY_W-1:0] tally_nxt;

`ifdef COUNT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] RTMR_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RTMR_PERIOD = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rtmr, rtmr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) rtmr <= '0;
    else        rtmr <= rtmr_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      dcnt    <= '0;
      count   <= 1'b0;
      pressed <= 1'b0;
      tally   <= '0;
    end else begin
      state   <= state_nxt;
      dcnt    <= dcnt_nxt;
      count   <= count_nxt;
      pressed <= pressed_nxt;
      tally   <= tally_nxt;
    end
  end

  // A level is accepted after the entry sample plus DEBOUNCE_CYCLES further
  // matching samples, so count rises DEBOUNCE_CYCLES+2 edges after btn_in is first sampled.
  always_comb begin
    state_nxt   = state;
    dcnt_nxt    = dcnt;
    count_nxt   = 1'b0;
    pressed_nxt = pressed;
    tally_nxt   = tally;
`ifdef COUNT_AUTOREPEAT_EN
    rtmr_nxt    = rtmr;
`endif
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = DEB_PRESS;
          dcnt_nxt  = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else if (dcnt == DCNT_TC) begin
          state_nxt   = HELD;
          dcnt_nxt    = '0;
          count_nxt   = 1'b1;
          pressed_nxt = 1'b1;
          tally_nxt   = tally + 1'b1;
`ifdef COUNT_AUTOREPEAT_EN
          rtmr_nxt    = RTMR_DELAY;
`endif
        end else begin
          dcnt_nxt = (dcnt < DCNT_TC) ? dcnt + 1'b1 : dcnt;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = DEB_REL;
          dcnt_nxt  = DW'(1);
`ifdef COUNT_AUTOREPEAT_EN
          rtmr_nxt  = '0;
        end else if (rtmr == '0) begin
          count_nxt = 1'b1;
          tally_nxt = tally + 1'b1;
          rtmr_nxt  = RTMR_PERIOD;
        end else begin
          rtmr_nxt  = rtmr - 1'b1;
`endif
        end
      end
      DEB_REL: begin
        if (btn_s) begin
          state_nxt = HELD;
          dcnt_nxt  = '0;
`ifdef COUNT_AUTOREPEAT_EN
          rtmr_nxt  = RTMR_DELAY;
`endif
        end else if (dcnt == DCNT_TC) begin
          state_nxt   = IDLE;
          dcnt_nxt    = '0;
          pressed_nxt = 1'b0;
        end else begin
          dcnt_nxt = (dcnt < DCNT_TC) ? dcnt + 1'b1 : dcnt;
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end

endmodule
